slowdown_fifo: RTL and testbench

//  Next-generation fetch-bundle serializer between decode and the per-warp ibuffer.

---
 rtl/slowdown_fifo.sv | 154 +++++++++++++++
 tb/tb_slowdown_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/slowdown_fifo.sv
// slowdown_fifo
//   Fetch-bundle serializer between decode and the per-warp ibuffer. Queues up to
//   DEPTH bundles of NUM_FETCH control words (each with a per-lane valid mask) and
//   emits one control word per accepted output handshake, lowest set lane first.
//   A new bundle is accepted in the same cycle the head bundle drains, so
//   back-to-back bundles stream without a bubble.
//
//   Optional feature macro: SLOWDOWN_FIFO_BYPASS_EN
//     When defined, an offered bundle arriving at an empty queue is presented on the
//     output in the same cycle; only its unconsumed lanes (if any) are stored.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-high
//   flush_i        drop all held bundles (and any bundle offered this cycle)
//   in_valid_i     bundle offered
//   in_ready_o     bundle can be accepted (combinational from out_ready_i/out_grant_i)
//   in_mask_i      per-lane valid mask of the offered bundle
//   in_signals_i   offered bundle, lane i at [BUFFER_WIDTH*i +: BUFFER_WIDTH]
//   out_valid_o    control word available
//   out_ready_i    consumer ready
//   out_grant_i    issue grant; a word is consumed only with ready and grant
//   out_signals_o  current control word
//   out_last_o     current word is the last valid lane of its bundle
//   count_o        number of bundles held
module slowdown_fifo #(
  parameter int NUM_FETCH    = 2,
  parameter int BUFFER_WIDTH = 155,
  parameter int DEPTH        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [NUM_FETCH-1:0]              in_mask_i,
  input  logic [BUFFER_WIDTH*NUM_FETCH-1:0] in_signals_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  input  logic                              out_grant_i,
  output logic [BUFFER_WIDTH-1:0]           out_signals_o,
  output logic                              out_last_o,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (NUM_FETCH > 1) ? $clog2(NUM_FETCH) : 1;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [LW-1:0] low_lane(input logic [NUM_FETCH-1:0] m);
    logic [LW-1:0] l;
    l = '0;
    for (int i = NUM_FETCH - 1; i >= 0; i--) begin
      if (m[i]) l = LW'(i);
    end
    return l;
  endfunction

  function automatic logic one_hot(input logic [NUM_FETCH-1:0] m);
    return (m != '0) && ((m & (m - NUM_FETCH'(1))) == '0);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [NUM_FETCH-1:0]              mask_q [DEPTH];
  logic [BUFFER_WIDTH*NUM_FETCH-1:0] data_q [DEPTH];
  logic [PW-1:0]                     rd_ptr;
  logic [PW-1:0]                     wr_ptr;
  logic [CW-1:0]                     count;

  logic [NUM_FETCH-1:0]              head_mask;
  logic [BUFFER_WIDTH*NUM_FETCH-1:0] head_data;
  logic                              bypass;
  logic [NUM_FETCH-1:0]              sel_mask;
  logic [BUFFER_WIDTH*NUM_FETCH-1:0] sel_data;
  logic [LW-1:0]                     lane;
  logic [NUM_FETCH-1:0]              clr;
  logic                              adv;
  logic                              pop;
  logic                              in_fire;
  logic                              push;
  logic [NUM_FETCH-1:0]              wr_mask;

  assign head_mask = mask_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

`ifdef SLOWDOWN_FIFO_BYPASS_EN
  assign bypass = (count == '0) & ~flush_i & in_valid_i & (in_mask_i != '0);
`else
  assign bypass = 1'b0;
`endif

  // The presented bundle is either the stored head or, in bypass, the offered one.
  assign sel_mask = bypass ? in_mask_i : head_mask;
  assign sel_data = bypass ? in_signals_i : head_data;
  assign lane     = low_lane(sel_mask);
  assign clr      = NUM_FETCH'(1) << lane;

  assign out_valid_o   = (count != '0) | bypass;
  assign out_signals_o = sel_data[int'(lane) * BUFFER_WIDTH +: BUFFER_WIDTH];
  assign out_last_o    = one_hot(sel_mask);
  assign count_o       = count;

  assign adv = out_valid_o & out_ready_i & out_grant_i;
  // A bypassed bundle never occupies a slot, so its last lane frees nothing.
  assign pop = adv & out_last_o & ~bypass;

  // Draining the head frees its slot for the offered bundle in the same cycle.
  assign in_ready_o = (count != CW'(DEPTH)) | pop;
  assign in_fire    = in_valid_i & in_ready_o & ~flush_i;
  assign push       = in_fire & (in_mask_i != '0) & ~(bypass & adv & out_last_o);
  assign wr_mask    = (bypass & adv) ? (in_mask_i & ~clr) : in_mask_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      if (adv && !bypass) begin
        mask_q[rd_ptr] <= head_mask & ~clr;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // When full, wr_ptr equals rd_ptr here, so this write overrides the clear above.
      if (push) begin
        mask_q[wr_ptr] <= wr_mask;
        data_q[wr_ptr] <= in_signals_i;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_slowdown_fifo.sv
// tb_slowdown_fifo
//   Directed bench for slowdown_fifo with NUM_FETCH=2, BUFFER_WIDTH=155, DEPTH=2.
//   Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_slowdown_fifo;
  localparam int NF = 2;
  localparam int BW = 155;
  localparam int D  = 2;

  localparam logic [BW-1:0] A1 = 155'h0A11;
  localparam logic [BW-1:0] B1 = 155'h0B11;
  localparam logic [BW-1:0] B2 = 155'h0B22;
  localparam logic [BW-1:0] X2 = 155'h0DEAD;
  localparam logic [BW-1:0] C3 = 155'h0C33;
  localparam logic [BW-1:0] D3 = 155'h0D33;
  localparam logic [BW-1:0] E4 = 155'h0E44;
  localparam logic [BW-1:0] F4 = 155'h0F44;
  localparam logic [BW-1:0] G4 = 155'h1044;
  localparam logic [BW-1:0] H4 = 155'h1144;
  localparam logic [BW-1:0] I5 = 155'h1255;
  localparam logic [BW-1:0] J5 = 155'h1355;
  localparam logic [BW-1:0] K5 = 155'h1455;
  localparam logic [BW-1:0] L5 = 155'h1555;
  localparam logic [BW-1:0] M7 = 155'h1677;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [NF-1:0]     in_mask;
  logic [BW*NF-1:0]  in_signals;
  logic              out_valid;
  logic              out_ready;
  logic              out_grant;
  logic [BW-1:0]     out_signals;
  logic              out_last;
  logic [$clog2(D+1)-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  slowdown_fifo #(.NUM_FETCH(NF), .BUFFER_WIDTH(BW), .DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_mask_i     (in_mask),
    .in_signals_i  (in_signals),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_grant_i   (out_grant),
    .out_signals_o (out_signals),
    .out_last_o    (out_last),
    .count_o       (count)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [NF-1:0] m,
                       input logic [BW-1:0] hi, input logic [BW-1:0] lo);
    in_valid   = v;
    in_mask    = m;
    in_signals = {hi, lo};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; out_grant = 1'b0;
    offer(1'b0, 2'b00, '0, '0);
    tick; tick;
    chk("rst_valid", 160'(out_valid), 160'(1'b0));
    chk("rst_in_ready", 160'(in_ready), 160'(1'b1));
    chk("rst_signals", 160'(out_signals), 160'(0));
    chk("rst_last", 160'(out_last), 160'(1'b0));
    chk("rst_count", 160'(count), 160'(0));
    rst = 1'b0;

    // Full two-lane bundle: A then B.
    out_ready = 1'b1; out_grant = 1'b0;
    offer(1'b1, 2'b11, B1, A1); #1;
    chk("t1_in_ready", 160'(in_ready), 160'(1'b1));
    tick;
    offer(1'b0, 2'b00, '0, '0); out_grant = 1'b1; #1;
    chk("t1_valid_a", 160'(out_valid), 160'(1'b1));
    chk("t1_sig_a", 160'(out_signals), 160'(A1));
    chk("t1_last_a", 160'(out_last), 160'(1'b0));
    chk("t1_count_a", 160'(count), 160'(1));
    tick;
    chk("t1_sig_b", 160'(out_signals), 160'(B1));
    chk("t1_last_b", 160'(out_last), 160'(1'b1));
    chk("t1_count_b", 160'(count), 160'(1));
    tick;
    chk("t1_empty_valid", 160'(out_valid), 160'(1'b0));
    chk("t1_empty_count", 160'(count), 160'(0));

    // Mask 2'b10: lane 0 data never appears.
    out_grant = 1'b0;
    offer(1'b1, 2'b10, B2, X2);
    tick;
    offer(1'b0, 2'b00, '0, '0); out_grant = 1'b1; #1;
    chk("t2_valid", 160'(out_valid), 160'(1'b1));
    chk("t2_sig", 160'(out_signals), 160'(B2));
    chk("t2_last", 160'(out_last), 160'(1'b1));
    tick;
    chk("t2_empty", 160'(out_valid), 160'(1'b0));

    // Hold with ready=1, grant=0.
    out_grant = 1'b0;
    offer(1'b1, 2'b11, D3, C3);
    tick;
    offer(1'b0, 2'b00, '0, '0); #1;
    chk("t3_hold0", 160'(out_signals), 160'(C3));
    chk("t3_hold0_last", 160'(out_last), 160'(1'b0));
    tick;
    chk("t3_hold1", 160'(out_signals), 160'(C3));
    tick;
    chk("t3_hold2", 160'(out_signals), 160'(C3));
    chk("t3_hold2_last", 160'(out_last), 160'(1'b0));
    chk("t3_count", 160'(count), 160'(1));
    out_grant = 1'b1; #1;
    chk("t3_grant_sig", 160'(out_signals), 160'(C3));
    tick;
    chk("t3_adv_sig", 160'(out_signals), 160'(D3));
    chk("t3_adv_last", 160'(out_last), 160'(1'b1));
    tick;
    chk("t3_empty", 160'(count), 160'(0));

    // Fill, back-pressure, then push into the slot freed by a one-hot head.
    out_ready = 1'b0; out_grant = 1'b1;
    offer(1'b1, 2'b01, '0, E4);
    tick;
    offer(1'b1, 2'b11, G4, F4); #1;
    chk("t4_ready_one", 160'(in_ready), 160'(1'b1));
    chk("t4_count_one", 160'(count), 160'(1));
    tick;
    offer(1'b1, 2'b01, '0, H4); #1;
    chk("t4_count_full", 160'(count), 160'(2));
    chk("t4_ready_full", 160'(in_ready), 160'(1'b0));
    tick;
    chk("t4_still_full", 160'(count), 160'(2));
    chk("t4_head_e", 160'(out_signals), 160'(E4));
    out_ready = 1'b1; #1;
    chk("t4_ready_pop", 160'(in_ready), 160'(1'b1));
    chk("t4_last_e", 160'(out_last), 160'(1'b1));
    tick;
    offer(1'b0, 2'b00, '0, '0); #1;
    chk("t4_count_swap", 160'(count), 160'(2));
    chk("t4_sig_f", 160'(out_signals), 160'(F4));
    chk("t4_last_f", 160'(out_last), 160'(1'b0));
    tick;
    chk("t4_sig_g", 160'(out_signals), 160'(G4));
    chk("t4_last_g", 160'(out_last), 160'(1'b1));
    chk("t4_count_g", 160'(count), 160'(2));
    tick;
    chk("t4_sig_h", 160'(out_signals), 160'(H4));
    chk("t4_count_h", 160'(count), 160'(1));
    tick;
    chk("t4_empty", 160'(count), 160'(0));

    // Flush with a partially consumed head and a bundle offered.
    out_grant = 1'b0;
    offer(1'b1, 2'b11, J5, I5);
    tick;
    offer(1'b0, 2'b00, '0, '0); out_grant = 1'b1; #1;
    chk("t5_sig_i", 160'(out_signals), 160'(I5));
    tick;
    chk("t5_sig_j", 160'(out_signals), 160'(J5));
    flush = 1'b1;
    offer(1'b1, 2'b11, L5, K5);
    tick;
    flush = 1'b0;
    offer(1'b0, 2'b00, '0, '0); #1;
    chk("t5_flush_valid", 160'(out_valid), 160'(1'b0));
    chk("t5_flush_count", 160'(count), 160'(0));
    tick;
    chk("t5_dropped_valid", 160'(out_valid), 160'(1'b0));
    chk("t5_dropped_count", 160'(count), 160'(0));

    // Empty mask: handshake completes, nothing stored.
    offer(1'b1, 2'b00, B1, A1); #1;
    chk("t6_in_ready", 160'(in_ready), 160'(1'b1));
    tick;
    offer(1'b0, 2'b00, '0, '0); #1;
    chk("t6_valid", 160'(out_valid), 160'(1'b0));
    chk("t6_count", 160'(count), 160'(0));

`ifdef SLOWDOWN_FIFO_BYPASS_EN
    // One-hot bundle into an empty queue is consumed in the same cycle.
    out_ready = 1'b1; out_grant = 1'b1;
    offer(1'b1, 2'b01, '0, M7); #1;
    chk("t7_byp_valid", 160'(out_valid), 160'(1'b1));
    chk("t7_byp_sig", 160'(out_signals), 160'(M7));
    chk("t7_byp_last", 160'(out_last), 160'(1'b1));
    tick;
    offer(1'b0, 2'b00, '0, '0); #1;
    chk("t7_byp_count", 160'(count), 160'(0));
    chk("t7_byp_empty", 160'(out_valid), 160'(1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
